// File: rtl/inst_load_ctrl.sv
// Purpose: byte-serial program loader; parses a 4-byte big-endian word count, then packs
//          bytes big-endian into 32-bit words written to instruction memory from address 0.
// Latency: mem_we asserts exactly 1 cycle after the rx_valid carrying a word's 4th byte.
// Backpressure: none; rx_valid is a one-cycle strobe that is always accepted in HEADER/DATA.
//
// Ports:
//   CLK, reset            clock (rising edge), asynchronous active-low reset
//   loader_enable         level; rising edge starts a load, low aborts / acknowledges
//   rx_data, rx_valid     received byte and its one-cycle strobe
//   mem_we/addr/wdata     instruction-memory write port, one-cycle pulse per word
//   cpu_stall             high while no complete program is resident or a load is running
//   busy/done/error       status: HEADER-or-DATA / DONE / ERROR
//   words_loaded          words written by the current or last load
module inst_load_ctrl #(
    parameter int INST_MEM_WIDTH = 10
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic                      loader_enable,
    input  logic [7:0]                rx_data,
    input  logic                      rx_valid,
    output logic                      mem_we,
    output logic [INST_MEM_WIDTH-1:0] mem_addr,
    output logic [31:0]               mem_wdata,
    output logic                      cpu_stall,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [INST_MEM_WIDTH:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_DATA,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [32:0]           DEPTH   = 33'd1 << INST_MEM_WIDTH;
    localparam logic [INST_MEM_WIDTH:0] WL_ONE = (INST_MEM_WIDTH+1)'(1);

    state_t                  state;
    logic                    en_q;        // previous loader_enable, for edge detection
    logic                    loaded;      // a complete program is resident
    logic [1:0]              byte_cnt;
    logic [23:0]             hdr;         // first three header bytes
    logic [23:0]             pack;        // first three bytes of the word in flight
    logic [INST_MEM_WIDTH:0] n_words;

    // Full header / word as it would look including the byte on rx_data this cycle.
    logic [31:0] hdr_full;
    logic        hdr_too_big;
    assign hdr_full    = {hdr, rx_data};
    assign hdr_too_big = {1'b0, hdr_full} > DEPTH;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            en_q         <= 1'b0;
            loaded       <= 1'b0;
            byte_cnt     <= 2'd0;
            hdr          <= '0;
            pack         <= '0;
            n_words      <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            cpu_stall    <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
        end else begin
            en_q   <= loader_enable;
            mem_we <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (loader_enable && !en_q) begin
                        state        <= S_HEADER;
                        loaded       <= 1'b0;
                        words_loaded <= '0;
                        byte_cnt     <= 2'd0;
                        busy         <= 1'b1;
                        cpu_stall    <= 1'b1;
                    end
                end

                S_HEADER: begin
                    if (!loader_enable) begin
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                        cpu_stall <= ~loaded;
                    end else if (rx_valid) begin
                        hdr      <= hdr_full[23:0];
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            busy <= 1'b0;
                            if (hdr_full == 32'd0) begin
                                state     <= S_DONE;
                                done      <= 1'b1;
                                loaded    <= 1'b1;
                                cpu_stall <= 1'b0;
                            end else if (hdr_too_big) begin
                                state     <= S_ERROR;
                                error     <= 1'b1;
                                cpu_stall <= 1'b1;
                            end else begin
                                state    <= S_DATA;
                                busy     <= 1'b1;
                                n_words  <= hdr_full[INST_MEM_WIDTH:0];
                                byte_cnt <= 2'd0;
                            end
                        end
                    end
                end

                S_DATA: begin
                    if (!loader_enable) begin
                        // Partial word is dropped; any write issued last edge still completes.
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                        cpu_stall <= ~loaded;
                    end else if (mem_we && words_loaded == n_words) begin
                        // Final word is on the bus this cycle; finish as mem_we drops.
                        state     <= S_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        loaded    <= 1'b1;
                        cpu_stall <= 1'b0;
                    end else if (rx_valid) begin
                        pack     <= {pack[15:0], rx_data};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            mem_we       <= 1'b1;
                            mem_addr     <= words_loaded[INST_MEM_WIDTH-1:0];
                            mem_wdata    <= {pack, rx_data};
                            words_loaded <= words_loaded + WL_ONE;
                        end
                    end
                end

                S_DONE: begin
                    if (!loader_enable) begin
                        state     <= S_IDLE;
                        done      <= 1'b0;
                        cpu_stall <= ~loaded;
                    end
                end

                S_ERROR: begin
                    if (!loader_enable) begin
                        state     <= S_IDLE;
                        error     <= 1'b0;
                        cpu_stall <= ~loaded;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/inst_load_ctrl.md
Name: inst_load_ctrl

Overview:
- Sequences program loading into inst_memory over a byte-serial link (UART receiver output).
- Parses a 4-byte big-endian word-count header, then packs the following bytes into 32-bit instructions.
- Writes each instruction to consecutive instruction-memory addresses starting at 0.
- Holds the CPU stalled until a complete, valid program is resident.

Parameters:
INST_MEM_WIDTH, 10, instruction-memory address width in words; depth = 2^INST_MEM_WIDTH.

Ports:
CLK  input  1  clock; all logic on rising edge
reset  input  1  asynchronous, active-low reset
loader_enable  input  1  level; rising edge starts a load, low aborts or acknowledges
rx_data  input  8  received byte
rx_valid  input  1  one-cycle strobe; rx_data valid this cycle
mem_we  output  1  instruction-memory write enable, one-cycle pulse per word
mem_addr  output  INST_MEM_WIDTH  write address
mem_wdata  output  32  write data
cpu_stall  output  1  high = CPU must not fetch
busy  output  1  high in HEADER or DATA
done  output  1  high in DONE
error  output  1  high in ERROR
words_loaded  output  INST_MEM_WIDTH+1  words written by the current/last load

Behaviour:
- Reset (reset=0, async):
  - State -> IDLE.
  - mem_we, mem_addr, mem_wdata, busy, done, error, words_loaded all 0.
  - Internal loaded flag = 0; byte counter = 0.
  - cpu_stall = 1.
- cpu_stall = ~loaded | busy, registered.
- IDLE:
  - A loader_enable rising edge (sampled 0 then 1) -> HEADER. Clears loaded, words_loaded and the byte counter.
  - rx_valid is ignored.
- HEADER:
  - Each rx_valid shifts rx_data into N. The first byte is the MSB; 4 bytes total.
  - On the 4th byte:
    - N == 0 -> DONE.
    - N > 2^INST_MEM_WIDTH -> ERROR; no writes occur.
    - Otherwise -> DATA.
- DATA:
  - Bytes are packed big-endian; the first byte of a word goes to bits [31:24].
  - On the cycle after the 4th byte of a word is sampled:
    - mem_we = 1 for exactly one cycle.
    - mem_addr = word index (0, 1, 2, ...).
    - mem_wdata = packed word.
    - words_loaded increments in the same cycle.
  - Latency from last-byte rx_valid to mem_we is exactly 1 cycle.
  - After the write of word N-1 -> DONE, on the same edge that drops mem_we.
  - A byte arriving in the same cycle as a pending mem_we is accepted. The packing register is separate from the write-data register.
- DONE:
  - done = 1 and loaded = 1, so cpu_stall = 0.
  - rx_valid is ignored.
  - loader_enable low -> IDLE. loaded stays 1, so the CPU keeps running.
- ERROR:
  - error = 1; loaded = 0, so cpu_stall = 1.
  - rx_valid is ignored.
  - loader_enable low -> IDLE, which clears error.
- Abort:
  - loader_enable low while in HEADER or DATA -> IDLE next cycle.
  - error is not raised, loaded stays 0, and the partial byte is discarded. Already-written words stay in memory.
  - An rx_valid in the same cycle as the abort is discarded.
  - A mem_we already scheduled for that cycle still completes.
- Address wrap: impossible by construction. N ≤ depth, so the largest address is 2^W−1 and words_loaded fits in W+1 bits.
- Byte counter: 2 bits, wraps 3 -> 0 per word; reset on entry to HEADER and DATA.
- A reset mid-load returns everything to reset values immediately.

Test Plan:
- Reset then enable, bytes 00 00 00 02, AA AA AA AA, FF FF 00 00 -> two mem_we pulses, each 1 cycle after the 4th byte of its word: addr 0 = 0xAAAAAAAA, addr 1 = 0xFFFF0000. Then done=1, cpu_stall=0, words_loaded=2.
- Header 00 00 00 00 -> DONE directly after the 4th byte, no mem_we, cpu_stall=0.
- W=2, header 00 00 00 05 -> error=1, no mem_we, cpu_stall=1. loader_enable low -> error=0, state IDLE.
- W=2, header 00 00 00 04, 16 bytes 0x00..0x0F -> four writes with addr 0..3 and data 0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F; done=1, words_loaded=4.
- Load 1 word, then start a new load with N=2 and drop loader_enable after 6 bytes:
  - 1 new write to addr 0; no second write.
  - Returns to IDLE with cpu_stall=1 and done=0.
  - rx_valid while in IDLE produces no write.
- reset asserted mid-DATA -> all outputs 0 immediately except cpu_stall=1; the next load starts cleanly from the header.
